// File: rtl/regfile_scoreboard.sv
// Multi-port register file with per-register busy scoreboard.
// Issue reserves a destination (busy=1), writeback stores data and releases it.
module regfile_scoreboard #(
  parameter int unsigned WORD_SIZE = 16,
  parameter int unsigned REG_BITS  = 3,
  parameter int unsigned NUM_READ  = 2,
  parameter bit          ZERO_REG  = 1'b1,
  parameter bit          BYPASS    = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          write_en,
  input  logic [REG_BITS-1:0]           write_reg,
  input  logic [WORD_SIZE-1:0]          write_data,
  input  logic                          reserve_en,
  input  logic [REG_BITS-1:0]           reserve_reg,
  output logic                          reserve_stall,
  input  logic [NUM_READ*REG_BITS-1:0]  read_reg,
  output logic [NUM_READ*WORD_SIZE-1:0] read_data,
  output logic [NUM_READ-1:0]           read_ready,
  output logic [2**REG_BITS-1:0]        busy_vec,
  output logic [REG_BITS:0]             pending_count
);

  localparam int unsigned NREGS = 2 ** REG_BITS;
  localparam int unsigned CW    = REG_BITS + 1;

  logic [WORD_SIZE-1:0] regs_q [NREGS];
  logic [NREGS-1:0]     busy_q, busy_d;
  logic [CW-1:0]        count_q, count_d;

  logic write_ok, reserve_zero, reserve_ok, set_cnt, clr_cnt;

  // Writes to the hard-wired zero register are dropped entirely.
  assign write_ok     = write_en & ~(ZERO_REG && (write_reg == '0));
  assign reserve_zero = ZERO_REG && (reserve_reg == '0);

  // A busy register being released this cycle may be re-reserved at once.
  assign reserve_stall = reserve_en & ~reserve_zero & busy_q[reserve_reg]
                         & ~(write_en & (write_reg == reserve_reg));
  assign reserve_ok    = reserve_en & ~reserve_zero & ~reserve_stall;

  assign set_cnt = reserve_ok & ~busy_q[reserve_reg];
  assign clr_cnt = write_ok & busy_q[write_reg] & ~(reserve_ok & (reserve_reg == write_reg));

  always_comb begin
    busy_d = busy_q;
    if (write_ok) busy_d[write_reg] = 1'b0;
    // Reservation is applied last so it wins over a same-cycle release.
    if (reserve_ok) busy_d[reserve_reg] = 1'b1;
    count_d = count_q + CW'(set_cnt) - CW'(clr_cnt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      busy_q  <= '0;
      count_q <= '0;
    end else begin
      if (write_ok) regs_q[write_reg] <= write_data;
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    read_data  = '0;
    read_ready = '1;
    for (int p = 0; p < NUM_READ; p++) begin
      logic [REG_BITS-1:0] r;
      r = read_reg[p*REG_BITS +: REG_BITS];
      if (!rst_n) begin
        read_data[p*WORD_SIZE +: WORD_SIZE] = '0;
        read_ready[p]                       = 1'b1;
      end else if (ZERO_REG && (r == '0)) begin
        read_data[p*WORD_SIZE +: WORD_SIZE] = '0;
        read_ready[p]                       = 1'b1;
      end else if (BYPASS && write_ok && (write_reg == r)) begin
        read_data[p*WORD_SIZE +: WORD_SIZE] = write_data;
        read_ready[p]                       = 1'b1;
      end else begin
        read_data[p*WORD_SIZE +: WORD_SIZE] = regs_q[r];
        read_ready[p]                       = ~busy_q[r];
      end
    end
  end

  assign busy_vec      = busy_q;
  assign pending_count = count_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: one bypassing instance and one
// non-bypassing instance share all inputs.
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        write_en;
  logic [2:0]  write_reg;
  logic [15:0] write_data;
  logic        reserve_en;
  logic [2:0]  reserve_reg;
  logic [5:0]  read_reg;

  logic        stall_b, stall_n;
  logic [31:0] rdata_b, rdata_n;
  logic [1:0]  rready_b, rready_n;
  logic [7:0]  busy_b, busy_n;
  logic [3:0]  count_b, count_n;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_scoreboard #(.BYPASS(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .write_en(write_en), .write_reg(write_reg),
    .write_data(write_data), .reserve_en(reserve_en), .reserve_reg(reserve_reg),
    .reserve_stall(stall_b), .read_reg(read_reg), .read_data(rdata_b),
    .read_ready(rready_b), .busy_vec(busy_b), .pending_count(count_b)
  );

  regfile_scoreboard #(.BYPASS(1'b0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .write_en(write_en), .write_reg(write_reg),
    .write_data(write_data), .reserve_en(reserve_en), .reserve_reg(reserve_reg),
    .reserve_stall(stall_n), .read_reg(read_reg), .read_data(rdata_n),
    .read_ready(rready_n), .busy_vec(busy_n), .pending_count(count_n)
  );

  task automatic idle();
    write_en    = 1'b0;
    write_reg   = 3'd0;
    write_data  = 16'h0;
    reserve_en  = 1'b0;
    reserve_reg = 3'd0;
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    idle();
    read_reg = {3'd5, 3'd3};
    #2;
    checks++;
    if (rdata_b !== 32'h0) begin
      errors++; $display("FAIL reset_data got %h exp %h", rdata_b, 32'h0);
    end
    checks++;
    if (rready_b !== 2'b11) begin
      errors++; $display("FAIL reset_ready got %b exp %b", rready_b, 2'b11);
    end
    checks++;
    if (count_b !== 4'd0 || busy_b !== 8'h00) begin
      errors++; $display("FAIL reset_count got %0d/%h exp 0/00", count_b, busy_b);
    end
    @(negedge clk);
    rst_n = 1'b1;
    write_en = 1'b1; write_reg = 3'd2; write_data = 16'h1234;
    read_reg = {3'd5, 3'd2};
    @(negedge clk);
    idle();
    #1;
    checks++;
    if (rdata_b[15:0] !== 16'h1234) begin
      errors++; $display("FAIL write_r2 got %h exp %h", rdata_b[15:0], 16'h1234);
    end
    // Asynchronous reset in the middle of a low phase.
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (rdata_b[15:0] !== 16'h0 || rdata_n[15:0] !== 16'h0) begin
      errors++; $display("FAIL async_reset got %h/%h exp 0000", rdata_b[15:0], rdata_n[15:0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (rdata_b[15:0] !== 16'h0) begin
      errors++; $display("FAIL r2_after_reset got %h exp 0000", rdata_b[15:0]);
    end
  endtask

  task automatic test_reserve();
    @(negedge clk);
    reserve_en = 1'b1; reserve_reg = 3'd4;
    read_reg = {3'd5, 3'd4};
    #1;
    checks++;
    if (stall_b !== 1'b0) begin
      errors++; $display("FAIL reserve_first_stall got %b exp 0", stall_b);
    end
    @(negedge clk);
    #1;
    checks++;
    if (rready_b !== 2'b10 || busy_b !== 8'h10 || count_b !== 4'd1) begin
      errors++; $display("FAIL reserve_r4 got rdy %b busy %h cnt %0d exp 10/10/1",
                         rready_b, busy_b, count_b);
    end
    checks++;
    if (stall_b !== 1'b1) begin
      errors++; $display("FAIL reserve_again_stall got %b exp 1", stall_b);
    end
    @(negedge clk);
    idle();
    #1;
    checks++;
    if (busy_b !== 8'h10 || count_b !== 4'd1) begin
      errors++; $display("FAIL stall_no_change got busy %h cnt %0d exp 10/1", busy_b, count_b);
    end
  endtask

  task automatic test_write_reserve();
    @(negedge clk);
    write_en = 1'b1; write_reg = 3'd4; write_data = 16'hBEEF;
    reserve_en = 1'b1; reserve_reg = 3'd4;
    read_reg = {3'd4, 3'd4};
    #1;
    checks++;
    if (stall_b !== 1'b0) begin
      errors++; $display("FAIL wr_res_stall got %b exp 0", stall_b);
    end
    checks++;
    if (rdata_b !== 32'hBEEF_BEEF || rready_b !== 2'b11) begin
      errors++; $display("FAIL wr_res_bypass got %h/%b exp beefbeef/11", rdata_b, rready_b);
    end
    @(negedge clk);
    idle();
    #1;
    checks++;
    if (busy_b !== 8'h10 || count_b !== 4'd1) begin
      errors++; $display("FAIL wr_res_state got busy %h cnt %0d exp 10/1", busy_b, count_b);
    end
    checks++;
    if (rdata_b !== 32'hBEEF_BEEF || rready_b !== 2'b00) begin
      errors++; $display("FAIL wr_res_read got %h/%b exp beefbeef/00", rdata_b, rready_b);
    end
    checks++;
    if (rdata_n !== 32'hBEEF_BEEF || rready_n !== 2'b00) begin
      errors++; $display("FAIL wr_res_read_nb got %h/%b exp beefbeef/00", rdata_n, rready_n);
    end
  endtask

  task automatic test_bypass();
    @(negedge clk);
    write_en = 1'b1; write_reg = 3'd6; write_data = 16'hA5A5;
    read_reg = {3'd6, 3'd5};
    #1;
    checks++;
    if (rdata_b[31:16] !== 16'hA5A5 || rready_b[1] !== 1'b1) begin
      errors++; $display("FAIL bypass_on got %h/%b exp a5a5/1", rdata_b[31:16], rready_b[1]);
    end
    checks++;
    if (rdata_n[31:16] !== 16'h0000 || rready_n[1] !== 1'b1) begin
      errors++; $display("FAIL bypass_off got %h/%b exp 0000/1", rdata_n[31:16], rready_n[1]);
    end
    @(negedge clk);
    idle();
    read_reg = {3'd6, 3'd6};
    #1;
    checks++;
    if (rdata_n !== 32'hA5A5_A5A5 || rready_n !== 2'b11) begin
      errors++; $display("FAIL bypass_off_next got %h/%b exp a5a5a5a5/11", rdata_n, rready_n);
    end
  endtask

  task automatic test_zero_reg();
    @(negedge clk);
    write_en = 1'b1; write_reg = 3'd0; write_data = 16'hFFFF;
    reserve_en = 1'b1; reserve_reg = 3'd0;
    read_reg = {3'd0, 3'd0};
    #1;
    checks++;
    if (rdata_b !== 32'h0 || rready_b !== 2'b11 || stall_b !== 1'b0) begin
      errors++; $display("FAIL zero_same_cycle got %h/%b/%b exp 0/11/0",
                         rdata_b, rready_b, stall_b);
    end
    @(negedge clk);
    idle();
    #1;
    checks++;
    if (rdata_b !== 32'h0 || rdata_n !== 32'h0 || busy_b[0] !== 1'b0 || count_b !== 4'd1) begin
      errors++; $display("FAIL zero_after got %h/%h busy0 %b cnt %0d exp 0/0/0/1",
                         rdata_b, rdata_n, busy_b[0], count_b);
    end
  endtask

  task automatic test_fill_drain();
    // Release r4 so the count starts from zero.
    @(negedge clk);
    write_en = 1'b1; write_reg = 3'd4; write_data = 16'h0004;
    @(negedge clk);
    idle();
    #1;
    checks++;
    if (count_b !== 4'd0 || busy_b !== 8'h00) begin
      errors++; $display("FAIL release_r4 got cnt %0d busy %h exp 0/00", count_b, busy_b);
    end
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      reserve_en = 1'b1; reserve_reg = 3'(i);
      #1;
      checks++;
      if (stall_b !== 1'b0) begin
        errors++; $display("FAIL fill_stall_%0d got %b exp 0", i, stall_b);
      end
      @(negedge clk);
      idle();
      #1;
      checks++;
      if (count_b !== 4'(i)) begin
        errors++; $display("FAIL fill_count_%0d got %0d exp %0d", i, count_b, i);
      end
    end
    checks++;
    if (busy_b !== 8'hFE) begin
      errors++; $display("FAIL fill_busy got %h exp fe", busy_b);
    end
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      write_en = 1'b1; write_reg = 3'(i); write_data = 16'(i * 16'h0101);
      @(negedge clk);
      idle();
      #1;
      checks++;
      if (count_b !== 4'(7 - i)) begin
        errors++; $display("FAIL drain_count_%0d got %0d exp %0d", i, count_b, 7 - i);
      end
    end
    @(negedge clk);
    write_en = 1'b1; write_reg = 3'd3; write_data = 16'h3333;
    @(negedge clk);
    idle();
    read_reg = {3'd7, 3'd3};
    #1;
    checks++;
    if (count_b !== 4'd0 || busy_b !== 8'h00) begin
      errors++; $display("FAIL idle_write_count got %0d/%h exp 0/00", count_b, busy_b);
    end
    checks++;
    if (rdata_b !== 32'h0707_3333 || rready_b !== 2'b11) begin
      errors++; $display("FAIL drain_data got %h/%b exp 07073333/11", rdata_b, rready_b);
    end
  endtask

  initial begin
    test_reset();
    test_reserve();
    test_write_reserve();
    test_bypass();
    test_zero_reg();
    test_fill_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised successor of the single-write, dual-read CPU register file.
- Adds a configurable number of read ports, an optional hard-wired zero register and optional write-to-read bypass.
- Adds a per-register busy scoreboard: issue reserves a destination register, writeback releases it.
- Sits between decode/issue (reserve, read) and writeback (write) of the pipelined core.

Parameters:
- WORD_SIZE, 16, data width in bits.
- REG_BITS, 3, register index width; depth NREGS = 2**REG_BITS.
- NUM_READ, 2, number of read ports, 1..4.
- ZERO_REG, 1, if 1 then register 0 always reads 0, is never written and is never busy.
- BYPASS, 1, if 1 then a same-cycle write is forwarded to matching read ports.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- write_en  in  1  writeback strobe.
- write_reg  in  REG_BITS  writeback destination.
- write_data  in  WORD_SIZE  writeback data.
- reserve_en  in  1  issue request to mark a destination busy.
- reserve_reg  in  REG_BITS  destination to reserve.
- reserve_stall  out  1  combinational; 1 = reservation refused this cycle.
- read_reg  in  NUM_READ*REG_BITS  read indices; port p uses bits [p*REG_BITS +: REG_BITS].
- read_data  out  NUM_READ*WORD_SIZE  read data, packed the same way.
- read_ready  out  NUM_READ  per-port flag: 1 = data is final, not pending.
- busy_vec  out  NREGS  registered busy bit per register.
- pending_count  out  REG_BITS+1  registered count of busy registers.

Behaviour:
- Reset, asynchronous, active-low:
  - all NREGS registers go to 0, busy_vec goes to 0, pending_count goes to 0.
  - Takes effect immediately, including mid-operation; any in-flight reservations are lost.
  - While rst_n = 0, read_data reads 0 and read_ready reads all 1s.
- Write, at posedge clk when write_en = 1:
  - regs[write_reg] <= write_data and busy[write_reg] <= 0.
  - A write to a register that is not busy is legal; it updates data and busy stays 0.
  - With ZERO_REG = 1 and write_reg = 0, the write is ignored.
- Reservation:
  - reserve_stall = reserve_en & busy[reserve_reg] & ~(write_en & write_reg == reserve_reg).
  - With ZERO_REG = 1 and reserve_reg = 0: reserve_stall = 0 and no state change.
  - If reserve_en = 1 and reserve_stall = 0, busy[reserve_reg] <= 1 at the next posedge.
  - Same register written and reserved in the same cycle: the reservation wins, busy ends at 1 and regs is still updated with write_data.
  - A stalled reservation changes no state; the issue stage holds its request and retries.
- pending_count:
  - Next value = current + set − clear.
  - set = 1 if a reservation is accepted on a register that is not currently busy.
  - clear = 1 if a write releases a busy register that is not re-reserved in the same cycle.
  - Same-cycle release plus re-reserve of one register is net 0.
  - Never exceeds NREGS (NREGS−1 with ZERO_REG = 1); no wrap.
- Read ports, combinational and evaluated independently per port p, with r = read_reg[p]. First matching rule applies:
  - ZERO_REG = 1 and r = 0: data 0, ready 1.
  - BYPASS = 1, write_en = 1 and write_reg = r (and the write is not an ignored r0 write): data = write_data, ready 1.
  - Otherwise: data = regs[r], ready = ~busy[r].
- Read-during-write with BYPASS = 0: ports return the old value and ~busy of the old state; the new value is visible from the next cycle.
- All read ports may address the same register; their outputs are identical.

Test Plan:
- Reset, then read r3 on port 0 and r5 on port 1 → read_data 0/0, read_ready 2'b11, pending_count 0. Assert rst_n low mid-run after writing r2 = 16'h1234 → r2 reads 0 immediately.
- Reserve r4 (cycle 1), then read r4 → read_ready[0] = 0, busy_vec[4] = 1, pending_count 1. Reserve r4 again → reserve_stall = 1 and no state change.
- With r4 busy, drive write_en, r4, 16'hBEEF together with reserve_en, r4 → reserve_stall = 0. Next cycle busy_vec[4] = 1, pending_count still 1, r4 reads 16'hBEEF with ready 0.
- BYPASS = 1: write r6 = 16'hA5A5 while port 1 reads r6 in the same cycle → read_data[1] = 16'hA5A5, ready 1. Repeat with BYPASS = 0 → old value (0).
- ZERO_REG = 1: write r0 = 16'hFFFF and reserve r0 → r0 reads 0, ready 1, reserve_stall 0, busy_vec[0] = 0, pending_count unchanged.
- Reserve r1..r7 on consecutive cycles → pending_count = 7. Write all seven back in order → count decrements each cycle to 0, with no underflow on an extra write to an idle register.
